// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/execute memory-port arbiter.
package cpu_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OWN_W  = 2;

  localparam logic [DATA_W-1:0] ERR_RDATA = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic [OWN_W-1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  // Registered memory-port request payload
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Fetch, data and memory port bundle; slave = arbiter view, master = CPU/memory view.
interface cpu_mem_arbiter_if;
  import cpu_mem_arbiter_pkg::*;

  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic              i_err_o;
  logic [DATA_W-1:0] i_data_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [SEL_W-1:0]  d_sel_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_data_i;
  logic              d_ack_o;
  logic              d_err_o;
  logic [DATA_W-1:0] d_data_o;

  logic              m_req_o;
  logic              m_we_o;
  logic [SEL_W-1:0]  m_sel_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ack_i;
  logic [DATA_W-1:0] m_data_i;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_ack_o, i_err_o, i_data_o,
    input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
    output d_ack_o, d_err_o, d_data_o,
    output m_req_o, m_we_o, m_sel_o, m_addr_o, m_data_o,
    input  m_ack_i, m_data_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_ack_o, i_err_o, i_data_o,
    output d_req_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
    input  d_ack_o, d_err_o, d_data_o,
    input  m_req_o, m_we_o, m_sel_o, m_addr_o, m_data_o,
    output m_ack_i, m_data_i
  );

endinterface

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the single memory port between fetch (I) and execute (D):
// data priority with a fetch-starvation limit, plus a bus timeout.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cpu_mem_arbiter_if.slave bus,
  output logic [OWN_W-1:0] owner_o
);

  localparam int unsigned STREAK_W = $clog2(FAIR_LIMIT + 1);
  localparam int unsigned TOUT_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAIR_LIMIT);
  localparam logic [TOUT_W-1:0]   TOUT_LAST  = TOUT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q,  state_d;
  owner_e              owner_q,  owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TOUT_W-1:0]   tout_q,   tout_d;
  logic                m_req_q,  m_req_d;
  mem_req_t            mreq_q,   mreq_d;
  logic                i_ack_q,  i_ack_d;
  logic                i_err_q,  i_err_d;
  logic                d_ack_q,  d_ack_d;
  logic                d_err_q,  d_err_d;
  logic [DATA_W-1:0]   i_data_q, i_data_d;
  logic [DATA_W-1:0]   d_data_q, d_data_d;

  logic                grant_d_c;
  logic                grant_i_c;
  logic                err_c;
  logic [DATA_W-1:0]   rdata_c;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      tout_q   <= '0;
      m_req_q  <= 1'b0;
      mreq_q   <= '0;
      i_ack_q  <= 1'b0;
      i_err_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      tout_q   <= tout_d;
      m_req_q  <= m_req_d;
      mreq_q   <= mreq_d;
      i_ack_q  <= i_ack_d;
      i_err_q  <= i_err_d;
      d_ack_q  <= d_ack_d;
      d_err_q  <= d_err_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
    end
  end

  // Next-state, arbitration and response logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    tout_d   = tout_q;
    m_req_d  = m_req_q;
    mreq_d   = mreq_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    i_ack_d  = 1'b0;
    i_err_d  = 1'b0;
    d_ack_d  = 1'b0;
    d_err_d  = 1'b0;
    err_c    = 1'b0;
    rdata_c  = ERR_RDATA;

    // D wins ties until it has starved a waiting fetch FAIR_LIMIT times
    grant_d_c = bus.d_req_i && (!bus.i_req_i || (streak_q != STREAK_MAX));
    grant_i_c = bus.i_req_i && !grant_d_c;

    case (state_q)
      ST_IDLE: begin
        tout_d = '0;
        if (grant_d_c) begin
          state_d = ST_BUSY;
          owner_d = OWN_D;
          m_req_d = 1'b1;
          mreq_d  = '{we: bus.d_we_i, sel: bus.d_sel_i,
                      addr: bus.d_addr_i, data: bus.d_data_i};
          if (!bus.i_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_i_c) begin
          state_d  = ST_BUSY;
          owner_d  = OWN_I;
          m_req_d  = 1'b1;
          mreq_d   = '{we: 1'b0, sel: '1, addr: bus.i_addr_i, data: mreq_q.data};
          streak_d = '0;
        end
      end

      ST_BUSY: begin
        // An ack in the limit cycle takes precedence over the timeout
        if (bus.m_ack_i || (tout_q == TOUT_LAST)) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          err_c   = !bus.m_ack_i;
          rdata_c = bus.m_ack_i ? bus.m_data_i : ERR_RDATA;
          if (owner_q == OWN_I) begin
            i_ack_d  = !err_c;
            i_err_d  = err_c;
            i_data_d = rdata_c;
          end else begin
            d_ack_d  = !err_c;
            d_err_d  = err_c;
            d_data_d = rdata_c;
          end
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        tout_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        m_req_d = 1'b0;
      end
    endcase
  end

  assign bus.m_req_o  = m_req_q;
  assign bus.m_we_o   = mreq_q.we;
  assign bus.m_sel_o  = mreq_q.sel;
  assign bus.m_addr_o = mreq_q.addr;
  assign bus.m_data_o = mreq_q.data;
  assign bus.i_ack_o  = i_ack_q;
  assign bus.i_err_o  = i_err_q;
  assign bus.i_data_o = i_data_q;
  assign bus.d_ack_o  = d_ack_q;
  assign bus.d_err_o  = d_err_q;
  assign bus.d_data_o = d_data_q;
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized bench for cpu_mem_arbiter against a timeline/scoreboard reference model.
module tb_cpu_mem_arbiter;

  localparam int FAIR = 4;
  localparam int TOUT = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] owner_o;

  cpu_mem_arbiter_if bus();

  cpu_mem_arbiter #(.FAIR_LIMIT(FAIR), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs seen by the DUT during the previous cycle
  int          cyc = 0;
  logic        p_rst, p_ireq, p_dreq, p_dwe, p_ack;
  logic [3:0]  p_dsel;
  logic [31:0] p_iaddr, p_daddr, p_ddata, p_mdata;

  // Reference model: absolute-cycle timeline of the outstanding access
  bit          m_busy = 0;
  int          g_cyc = 0;
  int          resp_cyc = -100;
  int          streak = 0;
  bit          exp_mreq, exp_we, exp_ia, exp_ie, exp_da, exp_de;
  logic [1:0]  exp_own;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_mdata, exp_idata, exp_ddata;
  int          grant_log[$];

  // Requester and memory behaviour
  int rq_state[2];
  int left[2];
  int gap[2];
  int issued[2];
  int served[2];
  int gap_max = 0;
  bit allow_linger = 0;
  int mem_mode = 0;
  bit mem_on = 0;
  int mem_cnt = 0;
  int mem_wait = 0;
  int mem_accesses = 0;

  int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  task automatic respond(input bit err, input logic [31:0] data);
    m_busy   = 0;
    resp_cyc = cyc;
    exp_mreq = 0;
    if (exp_own == 2'b01) begin
      exp_ia = !err; exp_ie = err; exp_idata = data;
    end else begin
      exp_da = !err; exp_de = err; exp_ddata = data;
    end
  endtask

  task automatic step_check();
    bit dwin;
    bit chk_mdata;
    exp_ia = 0; exp_ie = 0; exp_da = 0; exp_de = 0;
    chk_mdata = 0;
    if (!p_rst) begin
      m_busy = 0; exp_mreq = 0; exp_own = 2'b00; exp_we = 0; exp_sel = 4'h0;
      exp_addr = 0; exp_mdata = 0; exp_idata = 0; exp_ddata = 0;
      streak = 0; resp_cyc = -100; chk_mdata = 1;
    end else begin
      if (!m_busy && cyc == resp_cyc + 1) exp_own = 2'b00;
      if (m_busy) begin
        if (p_ack) respond(1'b0, p_mdata);
        else if (cyc == g_cyc + TOUT + 1) respond(1'b1, 32'h0);
      end else if (cyc >= resp_cyc + 2 && (p_ireq || p_dreq)) begin
        dwin = p_dreq && (!p_ireq || streak != FAIR);
        if (dwin) begin
          exp_own = 2'b10; exp_we = p_dwe; exp_sel = p_dsel;
          exp_addr = p_daddr; exp_mdata = p_ddata;
          streak = p_ireq ? ((streak < FAIR) ? streak + 1 : streak) : 0;
          grant_log.push_back(2);
        end else begin
          exp_own = 2'b01; exp_we = 0; exp_sel = 4'hF; exp_addr = p_iaddr;
          streak = 0;
          grant_log.push_back(1);
        end
        m_busy = 1; g_cyc = cyc - 1; exp_mreq = 1;
      end
      chk_mdata = (exp_own == 2'b10);
    end
    check("m_req",  32'(bus.m_req_o), 32'(exp_mreq));
    check("owner",  32'(owner_o),     32'(exp_own));
    check("i_ack",  32'(bus.i_ack_o), 32'(exp_ia));
    check("i_err",  32'(bus.i_err_o), 32'(exp_ie));
    check("d_ack",  32'(bus.d_ack_o), 32'(exp_da));
    check("d_err",  32'(bus.d_err_o), 32'(exp_de));
    check("i_data", bus.i_data_o,     exp_idata);
    check("d_data", bus.d_data_o,     exp_ddata);
    check("m_we",   32'(bus.m_we_o),  32'(exp_we));
    check("m_sel",  32'(bus.m_sel_o), 32'(exp_sel));
    check("m_addr", bus.m_addr_o,     exp_addr);
    if (chk_mdata) check("m_data", bus.m_data_o, exp_mdata);
  endtask

  task automatic set_req(input int p, input bit v);
    if (p == 0) bus.i_req_i = v;
    else        bus.d_req_i = v;
  endtask

  task automatic drive_req(input int p);
    bit got;
    got = (p == 0) ? (bus.i_ack_o | bus.i_err_o) : (bus.d_ack_o | bus.d_err_o);
    case (rq_state[p])
      1: if (got) begin
        served[p]++;
        if (allow_linger && $urandom_range(0, 1) == 1) begin
          rq_state[p] = 2;
        end else begin
          set_req(p, 1'b0); rq_state[p] = 0; gap[p] = int'($urandom_range(0, gap_max));
        end
      end
      2: begin
        set_req(p, 1'b0); rq_state[p] = 0; gap[p] = int'($urandom_range(0, gap_max));
      end
      default: if (left[p] > 0) begin
        if (gap[p] == 0) begin
          if (p == 0) begin
            bus.i_addr_i = $urandom() & 32'hFFFF_FFFC;
          end else begin
            bus.d_we_i   = 1'($urandom_range(0, 1));
            bus.d_sel_i  = 4'($urandom_range(1, 15));
            bus.d_addr_i = $urandom();
            bus.d_data_i = $urandom();
          end
          set_req(p, 1'b1); left[p]--; issued[p]++; rq_state[p] = 1;
        end else begin
          gap[p]--;
        end
      end
    endcase
  endtask

  task automatic drive_mem();
    int r;
    bus.m_ack_i = 1'b0;
    if (bus.m_req_o) begin
      if (!mem_on) begin
        mem_on = 1; mem_cnt = 0; mem_accesses++;
        r = int'($urandom_range(0, 9));
        if (mem_mode == 1)      mem_wait = 0;
        else if (mem_mode == 2) mem_wait = -1;
        else if (r <= 5)        mem_wait = r % 4;
        else if (r == 6)        mem_wait = TOUT - 1;
        else if (r == 7)        mem_wait = TOUT;
        else                    mem_wait = -1;
      end
      if (mem_cnt == mem_wait) begin
        bus.m_ack_i = 1'b1; bus.m_data_i = $urandom();
      end
      mem_cnt++;
    end else begin
      mem_on = 0;
      if (mem_mode == 0 && $urandom_range(0, 3) == 0) begin
        bus.m_ack_i = 1'b1; bus.m_data_i = $urandom();
      end
    end
  endtask

  task automatic tick();
    p_rst = rst_i; p_ireq = bus.i_req_i; p_dreq = bus.d_req_i; p_dwe = bus.d_we_i;
    p_dsel = bus.d_sel_i; p_iaddr = bus.i_addr_i; p_daddr = bus.d_addr_i;
    p_ddata = bus.d_data_i; p_ack = bus.m_ack_i; p_mdata = bus.m_data_i;
    @(posedge clk_i);
    #1;
    cyc++;
    step_check();
    drive_mem();
    drive_req(0);
    drive_req(1);
  endtask

  task automatic start_phase(input int li, input int ld, input int gm, input bit lg, input int mm);
    left[0] = li; left[1] = ld; gap_max = gm; allow_linger = lg; mem_mode = mm;
    for (int p = 0; p < 2; p++) begin
      rq_state[p] = 0; gap[p] = 0; issued[p] = 0; served[p] = 0;
    end
    mem_accesses = 0;
    grant_log.delete();
  endtask

  task automatic run_phase(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (left[0] == 0 && left[1] == 0 && rq_state[0] == 0 && rq_state[1] == 0 && !m_busy);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    tick();
    tick();
    check({tag, "_served_i"}, 32'(served[0]), 32'(issued[0]));
    check({tag, "_served_d"}, 32'(served[1]), 32'(issued[1]));
    check({tag, "_accesses"}, 32'(mem_accesses), 32'(issued[0] + issued[1]));
  endtask

  initial begin
    int n;
    bus.i_req_i = 0; bus.i_addr_i = 0; bus.d_req_i = 0; bus.d_we_i = 0;
    bus.d_sel_i = 0; bus.d_addr_i = 0; bus.d_data_i = 0;
    bus.m_ack_i = 0; bus.m_data_i = 0;
    start_phase(0, 0, 0, 0, 1);
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;

    // Both ports hold requests continuously with zero-wait memory
    start_phase(2, 8, 0, 0, 1);
    run_phase("fair", 400);
    check("fair_grants", 32'(grant_log.size()), 32'd10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      check($sformatf("fair_order%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));

    // Random traffic: gaps, lingering requests, waits, limit-cycle acks, timeouts
    start_phase(25, 25, 3, 1, 0);
    run_phase("rand", 6000);

    // Reset in the middle of an access the memory never acknowledges
    start_phase(0, 1, 0, 0, 2);
    n = 0;
    while (!(m_busy && cyc >= g_cyc + 3) && n < 20) begin
      tick();
      n++;
    end
    check("rst_busy", 32'(m_busy), 32'd1);
    rst_i = 1'b0;
    bus.d_req_i = 1'b0;
    rq_state[1] = 0;
    left[1] = 0;
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("rst_no_resp", 32'(served[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
